// File: rtl/tt_um_nasser_hadi_dlatch.sv
// tt_um_nasser_hadi_dlatch: D-latch emulated by a clocked hold register plus
// a combinational transparency path, so no real latch is inferred.
// Ports: ui_in[0]=D, ui_in[1]=EN, ui_in[2]=CLR; uo_out[0]=Q, [1]=Q_n,
//   [2]=EN mirror, [3]=change pulse, [7:4]=change counter; uio_* unused (out=0, oe=0).
//   clk rising edge; rst_n is synchronous and active-HIGH despite its name; ena=0 freezes state.
// Optional: define DLATCH_SYNC_EN to pass D/EN/CLR through 2-flop synchronizers
//   (D-to-Q latency then becomes 2 clk cycles).
module tt_um_nasser_hadi_dlatch (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  logic       d;
  logic       en;
  logic       clr;
  logic       q_hold;
  logic       q_prev;
  logic       chg;
  logic [3:0] cnt;
  logic       q_hold_next;
  logic       held_change;
  logic       q;

`ifdef DLATCH_SYNC_EN
  // {CLR, EN, D} synchronizer stages; frozen with the rest of the state when ena=0.
  logic [2:0] sync_a;
  logic [2:0] sync_b;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      sync_a <= 3'b000;
      sync_b <= 3'b000;
    end else if (ena) begin
      sync_a <= ui_in[2:0];
      sync_b <= sync_a;
    end
  end

  assign d   = sync_b[0];
  assign en  = sync_b[1];
  assign clr = sync_b[2];
`else
  assign d   = ui_in[0];
  assign en  = ui_in[1];
  assign clr = ui_in[2];
`endif

  // The held value only follows D on edges where EN is high; a D change after
  // the last EN=1 edge but before EN falls is not captured.
  assign q_hold_next = en ? d : q_hold;
  assign held_change = (q_hold_next != q_hold);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      q_hold <= 1'b0;
      q_prev <= 1'b0;
      chg    <= 1'b0;
      cnt    <= 4'd0;
    end else if (ena) begin
      q_hold <= q_hold_next;
      q_prev <= q_hold;
      chg    <= held_change;
      if (clr)
        cnt <= 4'd0;
      else if (held_change)
        cnt <= cnt + 4'd1;
    end
  end

  // Transparency: zero-latency D-to-Q while EN is high.
  assign q = en ? d : q_hold;

  always_comb begin
    uo_out = 8'h00;
    if (!rst_n)
      uo_out = {cnt, chg, en, ~q, q};
  end

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  // q_prev is kept as debug state only; unused inputs are tied off here.
  logic unused_ok;
  assign unused_ok = &{ui_in[7:3], uio_in, q_prev, 1'b0};

endmodule

// File: tb/tb_tt_um_nasser_hadi_dlatch.sv
module tb_tt_um_nasser_hadi_dlatch;

  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       ena;
  logic       clk;
  logic       rst_n;

  int n_checks = 0;
  int n_fail   = 0;

  tt_um_nasser_hadi_dlatch dut (
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .ena    (ena),
    .clk    (clk),
    .rst_n  (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: the latch's remembered value, the change flag seen
  // on the previous edge, a modulo-16 event count, and (when synchronised)
  // a two-deep history of the raw {CLR,EN,D} inputs.
  bit       m_hold;
  bit       m_chg;
  int       m_cnt;
  bit [2:0] m_hist [2];

  function automatic bit [2:0] eff_inputs();
`ifdef DLATCH_SYNC_EN
    return m_hist[1];
`else
    return ui_in[2:0];
`endif
  endfunction

  function automatic logic [7:0] model_out();
    bit [2:0] s;
    bit       q;
    if (rst_n) return 8'h00;
    s = eff_inputs();
    q = s[1] ? s[0] : m_hold;
    return {m_cnt[3:0], m_chg, s[1], !q, q};
  endfunction

  function automatic void model_edge();
    bit [2:0] s;
    bit       new_hold;
    if (rst_n) begin
      m_hold = 0; m_chg = 0; m_cnt = 0;
      m_hist[0] = 3'b000; m_hist[1] = 3'b000;
      return;
    end
    if (!ena) return;
    s = eff_inputs();
    new_hold = s[1] ? s[0] : m_hold;
    m_chg = (new_hold != m_hold);
    if (s[2])       m_cnt = 0;
    else if (m_chg) m_cnt = (m_cnt + 1) % 16;
    m_hold = new_hold;
    m_hist[1] = m_hist[0];
    m_hist[0] = ui_in[2:0];
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive at the falling edge, check combinational outputs,
  // advance the model on the rising edge, check registered outputs.
  task automatic cycle(input logic r, input logic e, input logic [7:0] ui);
    @(negedge clk);
    rst_n = r; ena = e; ui_in = ui;
    uio_in = 8'($urandom);
    #1;
    check("pre_edge", uo_out, model_out());
    @(posedge clk);
    model_edge();
    #1;
    check("post_edge", uo_out, model_out());
    check("uio_out", uio_out, 8'h00);
    check("uio_oe", uio_oe, 8'h00);
  endtask

  // Mid-cycle input change (between rising and falling edge) with an
  // immediate combinational check.
  task automatic poke(input logic [7:0] ui);
    ui_in = ui;
    #1;
    check("poke", uo_out, model_out());
  endtask

  initial begin
    rst_n = 1'b1; ena = 1'b1; ui_in = 8'hFF; uio_in = 8'h00;

    // Reset dominates all inputs.
    cycle(1, 1, 8'hFF);
    cycle(1, 1, 8'hFF);
    check("reset_out", uo_out, 8'h00);
    cycle(0, 1, 8'h00);
    cycle(0, 1, 8'h00);
    cycle(0, 1, 8'h00);
    check("after_reset", uo_out, 8'b0000_0010);

    // Transparency with mid-cycle D toggles.
    cycle(0, 1, 8'h02);
    poke(8'h03);
`ifndef DLATCH_SYNC_EN
    check("transp_hi", {7'd0, uo_out[0]}, 8'd1);
`endif
    poke(8'h02);
`ifndef DLATCH_SYNC_EN
    check("transp_lo", {7'd0, uo_out[0]}, 8'd0);
`endif
    for (int i = 0; i < 4; i++) cycle(0, 1, (i % 2) ? 8'h02 : 8'h03);

    // Hold: capture 1, then EN low with D low.
    cycle(0, 1, 8'h03);
    cycle(0, 1, 8'h03);
    cycle(0, 1, 8'h03);
    for (int i = 0; i < 5; i++) cycle(0, 1, 8'h00);
    check("hold_low4", {4'd0, uo_out[3:0]}, 8'b0000_0001);

    // Clear, then 16 held-value changes wrap the counter back to zero.
    cycle(0, 1, 8'h04);
    cycle(0, 1, 8'h04);
    cycle(0, 1, 8'h04);
    for (int i = 0; i < 16; i++) cycle(0, 1, (i % 2) ? 8'h03 : 8'h02);
    cycle(0, 1, 8'h00);
    cycle(0, 1, 8'h00);
    cycle(0, 1, 8'h00);
`ifndef DLATCH_SYNC_EN
    check("cnt_wrap", {4'd0, uo_out[7:4]}, 8'd0);
`endif
    // CLR during a D change.
    cycle(0, 1, 8'h03);
    cycle(0, 1, 8'h06);
    cycle(0, 1, 8'h00);
    cycle(0, 1, 8'h00);
    cycle(0, 1, 8'h00);

    // ena gating: hold=1, then EN pulse with D=0 while frozen.
    cycle(0, 1, 8'h03);
    cycle(0, 1, 8'h03);
    cycle(0, 1, 8'h03);
    cycle(0, 1, 8'h00);
    cycle(0, 0, 8'h02);
    cycle(0, 0, 8'h00);
    cycle(0, 0, 8'h00);
    cycle(0, 0, 8'h00);
    check("ena_frozen_q", {7'd0, uo_out[0]}, 8'd1);
    cycle(0, 1, 8'h00);
    cycle(0, 1, 8'h00);

`ifdef DLATCH_SYNC_EN
    // Q must rise exactly two edges after D.
    cycle(0, 1, 8'h02);
    cycle(0, 1, 8'h02);
    cycle(0, 1, 8'h02);
    cycle(0, 1, 8'h03);
    check("sync_lat1", {7'd0, uo_out[0]}, 8'd0);
    cycle(0, 1, 8'h03);
    check("sync_lat2", {7'd0, uo_out[0]}, 8'd1);
`endif

    // Randomised traffic with occasional reset, ena gating and clears.
    for (int i = 0; i < 600; i++) begin
      logic [7:0] ui;
      ui = 8'($urandom);
      ui[2] = ($urandom_range(0, 7) == 0);
      cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), ui);
      if ($urandom_range(0, 3) == 0) poke(ui ^ 8'h01);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
